// File: rtl/hazard_pkg.sv
// Shared encodings and the per-stage hazard record for hazard_sched.
// Forwarding is compiled in only when HAZARD_FORWARD_EN is defined.
package hazard_pkg;

  localparam logic [1:0] FWD_RF      = 2'b00;
  localparam logic [1:0] FWD_EX_ALU  = 2'b01;
  localparam logic [1:0] FWD_MEM_ALU = 2'b10;
  localparam logic [1:0] FWD_MEM_LD  = 2'b11;

  localparam logic [1:0] HZ_NONE  = 2'b00;
  localparam logic [1:0] HZ_ID    = 2'b01;
  localparam logic [1:0] HZ_STORE = 2'b10;

  typedef struct packed {
    logic       valid;
    logic [4:0] rd;
    logic       regwrite;
    logic       load;
  } hz_rec_t;

  // x0 is hardwired to zero, so a writer targeting it never produces data.
  function automatic logic rec_live(input hz_rec_t r);
    return r.valid & r.regwrite & (r.rd != 5'd0);
  endfunction

endpackage

// File: rtl/hz_stage_rec.sv
// One pipeline-stage shadow record: async clear, hold on freeze,
// bubble insert (valid=0) otherwise load from the upstream stage.
module hz_stage_rec
  import hazard_pkg::*;
(
  input  logic    clk,
  input  logic    rst_n,
  input  logic    hold,
  input  logic    bubble,
  input  hz_rec_t d,
  output hz_rec_t q
);

  hz_rec_t rec_q;
  hz_rec_t rec_d;

  always_comb begin
    rec_d = rec_q;
    if (!hold) rec_d = bubble ? hz_rec_t'('0) : d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rec_q <= '0;
    else        rec_q <= rec_d;
  end

  assign q = rec_q;

endmodule

// File: rtl/hazard_sched.sv
// ID-side hazard scheduler for the 5-stage RV32I core: stalls, bubbles,
// operand/store forwarding selects and a saturating stall-cycle counter.
// Define HAZARD_FORWARD_EN to enable forwarding; otherwise any hit stalls.
module hazard_sched
  import hazard_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             id_valid,
  input  logic [4:0]       id_rs1,
  input  logic [4:0]       id_rs2,
  input  logic             id_rs1use,
  input  logic             id_rs2use,
  input  logic [1:0]       id_optype,
  input  logic [4:0]       id_rd,
  input  logic             id_regwrite,
  input  logic             id_load,
  input  logic             id_branch,
  input  logic             mem_busy,
  output logic             stall_pc,
  output logic             stall_ifid,
  output logic             flush_ifid,
  output logic             flush_idex,
  output logic             freeze,
  output logic [1:0]       fwd_a,
  output logic [1:0]       fwd_b,
  output logic             fwd_store,
  output logic [CNT_W-1:0] stall_cycles
);

`ifdef HAZARD_FORWARD_EN
  localparam logic FWD_ON = 1'b1;
`else
  localparam logic FWD_ON = 1'b0;
`endif

  hz_rec_t ex_rec, mem_rec, id_rec;
  logic    rs1_hit_ex, rs1_hit_mem, rs2_hit_ex, rs2_hit_mem;
  logic    store_exc, ld_stall, any_hit, hz_stall, adv_ex_bubble;
  logic [1:0] sel_a, sel_b;
  logic             fwd_store_q, fwd_store_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  function automatic logic [1:0] pick(input logic hit_ex, input logic hit_mem,
                                      input logic ex_ld, input logic mem_ld);
    if (hit_ex)       return ex_ld ? FWD_RF : FWD_EX_ALU;
    else if (hit_mem) return mem_ld ? FWD_MEM_LD : FWD_MEM_ALU;
    else              return FWD_RF;
  endfunction

  always_comb begin
    id_rec = '{valid: id_valid, rd: id_rd, regwrite: id_regwrite, load: id_load};

    rs1_hit_ex  = id_valid & id_rs1use & rec_live(ex_rec)  & (id_rs1 == ex_rec.rd);
    rs1_hit_mem = id_valid & id_rs1use & rec_live(mem_rec) & (id_rs1 == mem_rec.rd);
    rs2_hit_ex  = id_valid & id_rs2use & rec_live(ex_rec)  & (id_rs2 == ex_rec.rd);
    rs2_hit_mem = id_valid & id_rs2use & rec_live(mem_rec) & (id_rs2 == mem_rec.rd);

    // A store only needs rs2 at MEM, so a load in EX can feed it one cycle later.
    store_exc = FWD_ON & (id_optype == HZ_STORE) & rs2_hit_ex & !rs1_hit_ex & ex_rec.load;
    ld_stall  = (rs1_hit_ex | rs2_hit_ex) & ex_rec.load & !store_exc;
    any_hit   = rs1_hit_ex | rs1_hit_mem | rs2_hit_ex | rs2_hit_mem;
    hz_stall  = FWD_ON ? ld_stall : any_hit;

    sel_a = pick(rs1_hit_ex, rs1_hit_mem, ex_rec.load, mem_rec.load);
    sel_b = pick(rs2_hit_ex, rs2_hit_mem, ex_rec.load, mem_rec.load);

    adv_ex_bubble = !(id_valid & !hz_stall);

    fwd_store_d = mem_busy ? fwd_store_q : store_exc;

    cnt_d = cnt_q;
    if (!mem_busy && hz_stall && (cnt_q != {CNT_W{1'b1}})) cnt_d = cnt_q + CNT_W'(1);
  end

  hz_stage_rec u_ex (
    .clk    (clk),
    .rst_n  (rst_n),
    .hold   (mem_busy),
    .bubble (adv_ex_bubble),
    .d      (id_rec),
    .q      (ex_rec)
  );

  hz_stage_rec u_mem (
    .clk    (clk),
    .rst_n  (rst_n),
    .hold   (mem_busy),
    .bubble (1'b0),
    .d      (ex_rec),
    .q      (mem_rec)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fwd_store_q <= 1'b0;
      cnt_q       <= '0;
    end else begin
      fwd_store_q <= fwd_store_d;
      cnt_q       <= cnt_d;
    end
  end

  // Freeze dominates: every stall/flush request is suppressed while memory is busy.
  assign freeze       = mem_busy;
  assign stall_pc     = hz_stall & !mem_busy;
  assign stall_ifid   = hz_stall & !mem_busy;
  assign flush_idex   = hz_stall & !mem_busy;
  assign flush_ifid   = id_branch & id_valid & !hz_stall & !mem_busy;
  assign fwd_a        = (FWD_ON & !hz_stall) ? sel_a : FWD_RF;
  assign fwd_b        = (FWD_ON & !hz_stall) ? sel_b : FWD_RF;
  assign fwd_store    = fwd_store_q;
  assign stall_cycles = cnt_q;

endmodule

// File: tb/tb_hazard_sched.sv
// Directed bench for hazard_sched; expectations are hand-derived for the
// build selected by HAZARD_FORWARD_EN (defined or not).
`timescale 1ns/1ps
module tb_hazard_sched;
  import hazard_pkg::*;

`ifdef HAZARD_FORWARD_EN
  localparam bit F = 1'b1;
`else
  localparam bit F = 1'b0;
`endif

  logic clk, rst_n;
  logic id_valid, id_rs1use, id_rs2use, id_regwrite, id_load, id_branch, mem_busy;
  logic [4:0] id_rs1, id_rs2, id_rd;
  logic [1:0] id_optype;
  logic stall_pc, stall_ifid, flush_ifid, flush_idex, freeze, fwd_store;
  logic [1:0] fwd_a, fwd_b;
  logic [15:0] stall_cycles;
  logic s_stall_pc, s_stall_ifid, s_flush_ifid, s_flush_idex, s_freeze, s_fwd_store;
  logic [1:0] s_fwd_a, s_fwd_b;
  logic [1:0] s_stall_cycles;

  int tests = 0;
  int fails = 0;

  hazard_sched #(.CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_rs1use(id_rs1use), .id_rs2use(id_rs2use), .id_optype(id_optype), .id_rd(id_rd),
    .id_regwrite(id_regwrite), .id_load(id_load), .id_branch(id_branch), .mem_busy(mem_busy),
    .stall_pc(stall_pc), .stall_ifid(stall_ifid), .flush_ifid(flush_ifid),
    .flush_idex(flush_idex), .freeze(freeze), .fwd_a(fwd_a), .fwd_b(fwd_b),
    .fwd_store(fwd_store), .stall_cycles(stall_cycles)
  );

  // Narrow-counter copy to reach saturation in a few cycles.
  hazard_sched #(.CNT_W(2)) dut_sat (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_rs1use(id_rs1use), .id_rs2use(id_rs2use), .id_optype(id_optype), .id_rd(id_rd),
    .id_regwrite(id_regwrite), .id_load(id_load), .id_branch(id_branch), .mem_busy(mem_busy),
    .stall_pc(s_stall_pc), .stall_ifid(s_stall_ifid), .flush_ifid(s_flush_ifid),
    .flush_idex(s_flush_idex), .freeze(s_freeze), .fwd_a(s_fwd_a), .fwd_b(s_fwd_b),
    .fwd_store(s_fwd_store), .stall_cycles(s_stall_cycles)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  wire [8:0] ov = {stall_pc, stall_ifid, flush_ifid, flush_idex, freeze, fwd_a, fwd_b};

  function automatic logic [8:0] ev(input logic s, input logic fl, input logic fz,
                                    input logic [1:0] fa, input logic [1:0] fb);
    return {s, s, fl, s, fz, fa, fb};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drv(input logic v, input logic [4:0] r1, input logic u1,
                     input logic [4:0] r2, input logic u2, input logic [1:0] opt,
                     input logic [4:0] rd, input logic rw, input logic ld, input logic br);
    id_valid = v; id_rs1 = r1; id_rs1use = u1; id_rs2 = r2; id_rs2use = u2;
    id_optype = opt; id_rd = rd; id_regwrite = rw; id_load = ld; id_branch = br;
    #1;
  endtask

  task automatic nop();
    drv(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, HZ_NONE, 5'd0, 1'b0, 1'b0, 1'b0);
  endtask

  // lw x5,0(x1)
  task automatic lw_x5();
    drv(1'b1, 5'd1, 1'b1, 5'd0, 1'b0, HZ_ID, 5'd5, 1'b1, 1'b1, 1'b0);
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
    #1;
  endtask

  task automatic do_reset();
    nop();
    mem_busy = 1'b0;
    rst_n = 1'b0;
    #1;
    check("rst_outputs", 32'(ov), 32'(ev(0, 0, 0, 2'b00, 2'b00)));
    check("rst_cnt", 32'(stall_cycles), 32'd0);
    check("rst_fwd_store", 32'(fwd_store), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
  endtask

  initial begin
    mem_busy = 1'b0;
    rst_n = 1'b0;
    nop();

    // add x5,x1,x2 ; sub x6,x5,x3
    do_reset();
    drv(1'b1, 5'd1, 1'b1, 5'd2, 1'b1, HZ_ID, 5'd5, 1'b1, 1'b0, 1'b0);
    check("add_c1", 32'(ov), 32'(ev(0, 0, 0, 2'b00, 2'b00)));
    tick();
    drv(1'b1, 5'd5, 1'b1, 5'd3, 1'b1, HZ_ID, 5'd6, 1'b1, 1'b0, 1'b0);
    check("sub_ex_hit", 32'(ov), 32'(F ? ev(0, 0, 0, 2'b01, 2'b00) : ev(1, 0, 0, 2'b00, 2'b00)));
    tick();
    check("sub_cnt1", 32'(stall_cycles), F ? 32'd0 : 32'd1);
    check("sub_mem_hit", 32'(ov), 32'(F ? ev(0, 0, 0, 2'b10, 2'b00) : ev(1, 0, 0, 2'b00, 2'b00)));
    tick();
    nop();
    check("sub_cnt2", 32'(stall_cycles), F ? 32'd0 : 32'd2);

    // lw x5 ; add x6,x5,x5
    do_reset();
    lw_x5();
    tick();
    drv(1'b1, 5'd5, 1'b1, 5'd5, 1'b1, HZ_ID, 5'd6, 1'b1, 1'b0, 1'b0);
    check("lu_stall", 32'(ov), 32'(ev(1, 0, 0, 2'b00, 2'b00)));
    tick();
    check("lu_cnt", 32'(stall_cycles), 32'd1);
    check("lu_after", 32'(ov), 32'(F ? ev(0, 0, 0, 2'b11, 2'b11) : ev(1, 0, 0, 2'b00, 2'b00)));
    tick();
    nop();
    check("lu_cnt_end", 32'(stall_cycles), F ? 32'd1 : 32'd2);

    // lw x5 ; sw x5,4(x2)
    do_reset();
    lw_x5();
    tick();
    drv(1'b1, 5'd2, 1'b1, 5'd5, 1'b1, HZ_STORE, 5'd0, 1'b0, 1'b0, 1'b0);
    check("st_id", 32'(ov), 32'(F ? ev(0, 0, 0, 2'b00, 2'b00) : ev(1, 0, 0, 2'b00, 2'b00)));
    check("st_fs_id", 32'(fwd_store), 32'd0);
    tick();
    nop();
    check("st_fs_ex", 32'(fwd_store), F ? 32'd1 : 32'd0);
    check("st_cnt", 32'(stall_cycles), F ? 32'd0 : 32'd1);
    tick();
    check("st_fs_clr", 32'(fwd_store), 32'd0);

    // taken beq x1,x2 with independent operands
    do_reset();
    drv(1'b1, 5'd1, 1'b1, 5'd2, 1'b1, HZ_ID, 5'd0, 1'b0, 1'b0, 1'b1);
    check("br_flush", 32'(ov), 32'(ev(0, 1, 0, 2'b00, 2'b00)));
    tick();
    nop();
    check("br_once", 32'(ov), 32'(ev(0, 0, 0, 2'b00, 2'b00)));

    // lw x5 ; beq x5,x2
    do_reset();
    lw_x5();
    tick();
    drv(1'b1, 5'd5, 1'b1, 5'd2, 1'b1, HZ_ID, 5'd0, 1'b0, 1'b0, 1'b1);
    check("brd_stall", 32'(ov), 32'(ev(1, 0, 0, 2'b00, 2'b00)));
    tick();
    check("brd_c3", 32'(ov), 32'(F ? ev(0, 1, 0, 2'b11, 2'b00) : ev(1, 0, 0, 2'b00, 2'b00)));
    tick();
    check("brd_c4", 32'(ov), 32'(ev(0, 1, 0, 2'b00, 2'b00)));

    // freeze for 3 cycles during a load-use stall
    do_reset();
    lw_x5();
    tick();
    drv(1'b1, 5'd5, 1'b1, 5'd5, 1'b1, HZ_ID, 5'd6, 1'b1, 1'b0, 1'b0);
    mem_busy = 1'b1;
    #1;
    for (int i = 0; i < 3; i++) begin
      check("frz_out", 32'(ov), 32'(ev(0, 0, 1, 2'b00, 2'b00)));
      tick();
      check("frz_cnt", 32'(stall_cycles), 32'd0);
    end
    mem_busy = 1'b0;
    #1;
    check("frz_resume", 32'(ov), 32'(ev(1, 0, 0, 2'b00, 2'b00)));
    tick();
    check("frz_cnt_after", 32'(stall_cycles), 32'd1);
    check("frz_next", 32'(ov), 32'(F ? ev(0, 0, 0, 2'b11, 2'b11) : ev(1, 0, 0, 2'b00, 2'b00)));

    // reset while stalled drops everything at once
    rst_n = 1'b0;
    #1;
    check("midrst_out", 32'(ov), 32'(ev(0, 0, 0, 2'b00, 2'b00)));
    check("midrst_cnt", 32'(stall_cycles), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;

    // add x0,x1,x2 ; add x6,x0,x0 -> x0 never hits
    do_reset();
    drv(1'b1, 5'd1, 1'b1, 5'd2, 1'b1, HZ_ID, 5'd0, 1'b1, 1'b0, 1'b0);
    tick();
    drv(1'b1, 5'd0, 1'b1, 5'd0, 1'b1, HZ_ID, 5'd6, 1'b1, 1'b0, 1'b0);
    check("x0_nohit", 32'(ov), 32'(ev(0, 0, 0, 2'b00, 2'b00)));
    tick();
    check("x0_cnt", 32'(stall_cycles), 32'd0);

    // chain of three dependent loads lw x5,0(x5): saturates the 2-bit copy
    do_reset();
    lw_x5();
    tick();
    drv(1'b1, 5'd5, 1'b1, 5'd0, 1'b0, HZ_ID, 5'd5, 1'b1, 1'b1, 1'b0);
    repeat (F ? 6 : 9) tick();
    nop();
    check("chain_cnt", 32'(stall_cycles), F ? 32'd3 : 32'd6);
    check("sat_cnt", 32'(s_stall_cycles), 32'd3);
    drv(1'b1, 5'd5, 1'b1, 5'd5, 1'b1, HZ_ID, 5'd6, 1'b1, 1'b0, 1'b0);
    repeat (3) tick();
    check("sat_hold", 32'(s_stall_cycles), 32'd3);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
